// File: rtl/cam_fetch_pkg.sv
// Shared constants for the camshift pixel fetch stage: command layout, FSM encoding,
// and the word-count helper used when a command is loaded.
package cam_fetch_pkg;

   localparam int LEN_MSB        = 32;
   localparam int LEN_LSB        = 22;
   localparam int ADDR_MSB       = 21;
   localparam int BYTES_PER_WORD = 4;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_POP   = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_REQ   = 3'd3;
   localparam logic [2:0] S_WAIT  = 3'd4;
   localparam logic [2:0] S_DRAIN = 3'd5;

   // Words touched by a run of len pixels starting offset bytes into a word.
   function automatic logic [9:0] words_for(input logic [1:0] offset, input logic [10:0] len);
      logic [11:0] span;
      span = {10'd0, offset} + {1'b0, len};
      return 10'((32'(span) + BYTES_PER_WORD - 1) / BYTES_PER_WORD);
   endfunction

endpackage

// File: rtl/cam_word_fifo.sv
// Show-ahead 32-bit word buffer with occupancy count; rdata is the head word.
// Zero-latency read, write visible next cycle; writing while full is an assertion failure.
module cam_word_fifo #(
   parameter int DEPTH = 32,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr,
   input  logic [31:0]   wdata,
   input  logic          rd,
   output logic [31:0]   rdata,
   output logic [AW:0]   count,
   output logic          empty
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          full;
   logic          do_wr;
   logic          do_rd;

   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);
   assign do_rd = rd & ~empty;
   assign do_wr = wr & (~full | do_rd);
   assign rdata = mem[rptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_wr) wptr <= wptr + 1'b1;
         if (do_rd) rptr <= rptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wptr] <= wdata;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(wr && full && !rd));

endmodule

// File: rtl/cam_pixel_fetch.sv
// Turns window-row commands into credit-checked memory bursts and unpacks hue bytes.
// First byte 2 cycles after first read word; output holds under data_full, bursts wait for buffer space.
module cam_pixel_fetch
   import cam_fetch_pkg::*;
#(
   parameter int MAX_BURST = 16,
   parameter int BUF_DEPTH = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  frame_addr,
   input  logic        cmd_empty,
   input  logic [32:0] cmd_data,
   output logic        cmd_rd,
   output logic        mem_req,
   output logic [21:0] mem_addr,
   output logic [7:0]  mem_len,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   input  logic        data_full,
   output logic        data_wr,
   output logic [7:0]  data_out,
   output logic        busy
);

   localparam int CW = $clog2(BUF_DEPTH);
   localparam logic [CW:0] BUF_SLOTS = (CW+1)'(BUF_DEPTH);

   logic [2:0]   state;
   logic [1:0]   frame;
   logic [19:0]  word_ptr;
   logic [9:0]   words_left;
   logic [7:0]   rcv_cnt;
   logic [8:0]   rcv_next;
   logic         burst_done;
   logic [7:0]   burst;
   logic [CW:0]  occ;
   logic [CW:0]  free_space;
   logic         credit_ok;
   logic         fifo_empty;
   logic [31:0]  cur_word;
   logic [10:0]  rem_pix;
   logic [1:0]   bidx;
   logic         byte_valid;
   logic         load_byte;
   logic         pop_word;
   logic [10:0]  cmd_len;
   logic [21:0]  cmd_addr;

   assign cmd_len  = cmd_data[LEN_MSB:LEN_LSB];
   assign cmd_addr = cmd_data[ADDR_MSB:0];

   assign cmd_rd = (state == S_POP);
   assign busy   = (state == S_LOAD) | (state == S_REQ) | (state == S_WAIT) | (state == S_DRAIN);

   assign burst      = (words_left > 10'(MAX_BURST)) ? 8'(MAX_BURST) : words_left[7:0];
   assign free_space = BUF_SLOTS - occ;
   assign credit_ok  = (16'(free_space) >= 16'(burst));

   // rvalid may land in the grant cycle, so the count carries across REQ into WAIT
   assign rcv_next   = {1'b0, rcv_cnt} + {8'd0, mem_rvalid};
   assign burst_done = (state == S_WAIT) && (rcv_next >= {1'b0, mem_len});

   cam_word_fifo #(.DEPTH(BUF_DEPTH)) u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .wr    (mem_rvalid),
      .wdata (mem_rdata),
      .rd    (pop_word),
      .rdata (cur_word),
      .count (occ),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         frame      <= '0;
         word_ptr   <= '0;
         words_left <= '0;
         rcv_cnt    <= '0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         mem_len    <= '0;
      end else begin
         case (state)
            S_IDLE: if (!cmd_empty) state <= S_POP;
            S_POP:  state <= S_LOAD;
            S_LOAD: begin
               frame      <= frame_addr;
               word_ptr   <= cmd_addr[ADDR_MSB:2];
               words_left <= words_for(cmd_addr[1:0], cmd_len);
               rcv_cnt    <= '0;
               state      <= (cmd_len == '0) ? S_IDLE : S_REQ;
            end
            S_REQ: begin
               if (mem_rvalid) rcv_cnt <= rcv_next[7:0];
               if (mem_req) begin
                  if (mem_gnt) begin
                     mem_req <= 1'b0;
                     state   <= S_WAIT;
                  end
               end else if (credit_ok) begin
                  mem_req  <= 1'b1;
                  mem_addr <= {frame, word_ptr};
                  mem_len  <= burst;
               end
            end
            S_WAIT: begin
               if (burst_done) begin
                  word_ptr   <= word_ptr + 20'(mem_len);
                  words_left <= words_left - 10'(mem_len);
                  rcv_cnt    <= '0;
                  state      <= (words_left == 10'(mem_len)) ? S_DRAIN : S_REQ;
               end else begin
                  rcv_cnt <= rcv_next[7:0];
               end
            end
            S_DRAIN: if (rem_pix == '0 && !byte_valid && fifo_empty) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Unpacker: a word leaves the buffer when its last wanted byte is taken
   assign data_wr   = byte_valid & ~data_full;
   assign load_byte = (rem_pix != '0) & ~fifo_empty & (~byte_valid | ~data_full);
   assign pop_word  = load_byte & ((bidx == 2'd3) | (rem_pix == 11'd1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_pix    <= '0;
         bidx       <= '0;
         byte_valid <= 1'b0;
         data_out   <= '0;
      end else begin
         if (state == S_LOAD) begin
            rem_pix <= cmd_len;
            bidx    <= cmd_addr[1:0];
         end else if (load_byte) begin
            data_out <= cur_word[{bidx, 3'b000} +: 8];
            rem_pix  <= rem_pix - 1'b1;
            bidx     <= bidx + 1'b1;
         end
         if (load_byte)    byte_valid <= 1'b1;
         else if (data_wr) byte_valid <= 1'b0;
      end
   end

endmodule
